keyboard_buffer: RTL

Receives PS/2 keyboard frames, checks them, and queues scan codes in a small FIFO. It drives the `KEYBOARD` word that the data-bus hub gates onto `DATA_BUS` when `ENABLE_KEYBOARD_DATA_BUS` is high. Each bus read of the keyboard source pops one entry, so software polls bit 15 and then consumes the code in the same access.

---
 rtl/keyboard_pkg.sv | 21 ++
 rtl/keyboard_buffer_ps2_receiver.sv | 109 ++++++++++
 rtl/keyboard_buffer.sv | 88 ++++++++
 3 files changed

// File: rtl/keyboard_pkg.sv
// Shared types and constants for the PS/2 keyboard buffer.
// KEYBOARD_PARITY_CHECK_EN selects whether the odd-parity helper is used by the receiver.
package keyboard_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam int KBD_VALID_BIT = 15;
  localparam int KBD_OVF_BIT   = 14;
  localparam int PS2_DATA_BITS = 8;

  // PS/2 uses odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/keyboard_buffer_ps2_receiver.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, frame FSM and timeout.
// Defining KEYBOARD_PARITY_CHECK_EN rejects frames failing the odd-parity check.
module ps2_receiver
  import keyboard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  output logic [PS2_DATA_BITS-1:0] code,
  output logic                     push
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam int BW = $clog2(PS2_DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(PS2_DATA_BITS - 1);

  logic clk_meta, clk_sync, clk_prev;
  logic data_meta, data_sync;
  logic fall;

  rx_state_t                state;
  logic [BW-1:0]            bit_cnt;
  logic [PS2_DATA_BITS-1:0] shift;
  logic [TW-1:0]            timer;
`ifdef KEYBOARD_PARITY_CHECK_EN
  logic                     parity_bit;
`endif

  // Idle PS/2 lines are high, so the synchronizers reset high to avoid a false edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  assign fall = clk_prev & ~clk_sync;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= RX_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      code       <= '0;
      push       <= 1'b0;
      timer      <= '0;
`ifdef KEYBOARD_PARITY_CHECK_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      push <= 1'b0;
      if (state != RX_IDLE && !fall && timer == TIMEOUT_LAST) begin
        state <= RX_IDLE;
        timer <= '0;
      end else begin
        if (fall || state == RX_IDLE) timer <= '0;
        else                          timer <= timer + 1'b1;

        if (fall) begin
          unique case (state)
            RX_IDLE: begin
              if (!data_sync) begin
                state   <= RX_DATA;
                bit_cnt <= '0;
              end
            end
            RX_DATA: begin
              shift   <= {data_sync, shift[PS2_DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) state <= RX_PARITY;
            end
            RX_PARITY: begin
`ifdef KEYBOARD_PARITY_CHECK_EN
              parity_bit <= data_sync;
`endif
              state <= RX_STOP;
            end
            RX_STOP: begin
`ifdef KEYBOARD_PARITY_CHECK_EN
              if (data_sync && odd_parity_ok(shift, parity_bit)) begin
`else
              if (data_sync) begin
`endif
                code <= shift;
                push <= 1'b1;
              end
              state <= RX_IDLE;
            end
            default: state <= RX_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/keyboard_buffer.sv
// Keyboard scan-code FIFO feeding the KEYBOARD bus word; each bus read strobe pops one entry.
// Build option KEYBOARD_PARITY_CHECK_EN enables parity rejection in the receiver.
module keyboard_buffer
  import keyboard_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   PS2_CLK,
  input  logic                   PS2_DATA,
  input  logic                   ENABLE_KEYBOARD_DATA_BUS,
  output logic [15:0]            KEYBOARD,
  output logic                   KEY_AVAILABLE,
  output logic [$clog2(DEPTH):0] FIFO_COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [PS2_DATA_BITS-1:0] rx_code;
  logic                     rx_push;

  logic [PS2_DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [AW:0]              count;
  logic                     overflow;
  logic                     strobe_prev;

  logic pop_req, empty, full, do_pop, do_push;
  logic [PS2_DATA_BITS-1:0] head;

  ps2_receiver #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk     (CLK),
    .reset_n (RESET_N),
    .ps2_clk (PS2_CLK),
    .ps2_data(PS2_DATA),
    .code    (rx_code),
    .push    (rx_push)
  );

  assign pop_req = ENABLE_KEYBOARD_DATA_BUS & ~strobe_prev;
  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop_req & ~empty;
  assign do_push = rx_push & (~full | do_pop);

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= rx_code;
  end

  // A push into a full FIFO survives only when the head is being popped in the same cycle.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      strobe_prev <= 1'b0;
    end else begin
      strobe_prev <= ENABLE_KEYBOARD_DATA_BUS;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop_req && overflow)             overflow <= 1'b0;
      else if (rx_push && full && !do_pop) overflow <= 1'b1;
    end
  end

  always_comb begin
    head = empty ? '0 : mem[rd_ptr];
    KEYBOARD = '0;
    KEYBOARD[KBD_VALID_BIT] = ~empty;
    KEYBOARD[KBD_OVF_BIT]   = overflow;
    KEYBOARD[PS2_DATA_BITS-1:0] = head;
  end

  assign KEY_AVAILABLE = ~empty;
  assign FIFO_COUNT    = count;

endmodule
